// File: rtl/mplist_arb_pkg.sv
// Shared types and helpers for the message-list memory read arbiter.
// rr_next is the reference round-robin search used by the picker.
package mplist_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GRANT = 2'd2
    } arb_state_t;

    localparam int ARB_CNT_W   = 4;
    localparam int ARB_MAX_REQ = 16;

    // Search starts one past `last` and wraps at num_req; returns `last` when nothing is requesting.
    function automatic logic [ARB_CNT_W-1:0] rr_next(
        input logic [ARB_MAX_REQ-1:0] req,
        input logic [ARB_CNT_W-1:0]   last,
        input int                     num_req
    );
        logic [ARB_CNT_W-1:0] pick;
        logic                 found;
        int                   idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= ARB_MAX_REQ; k++) begin
            idx = (int'(last) + k) % num_req;
            if (!found && (k <= num_req) && req[idx[ARB_CNT_W-1:0]]) begin
                pick  = idx[ARB_CNT_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mplist_rr_picker.sv
// Combinational rotate-priority encoder: finds the first active request after `last`.
module mplist_rr_picker
    import mplist_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last,
    output logic               o_any,
    output logic [ID_W-1:0]    o_winner
);

    logic [ARB_MAX_REQ-1:0] w_req_pad;
    logic [ARB_CNT_W-1:0]   w_pick;

    assign w_req_pad = ARB_MAX_REQ'(i_req);
    assign w_pick    = rr_next(w_req_pad, ARB_CNT_W'(i_last), NUM_REQ);
    assign o_any     = |i_req;
    assign o_winner  = ID_W'(w_pick);

endmodule

// File: rtl/mplist_mem_rd_arb.sv
// Round-robin read arbiter: one command at a time onto a valid/ready memory port,
// credit-limited in-flight tracking, and response routing back to the requester.
module mplist_mem_rd_arb
    import mplist_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ID_W            = $clog2(NUM_REQ)
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   mem_rd_req,
    output logic [NUM_REQ-1:0]   mem_rd_gnt,
    output logic [NUM_REQ-1:0]   mem_rsp_vld,
    output logic                 mem_rd_valid,
    output logic [ID_W-1:0]      mem_rd_id,
    input  logic                 mem_rd_ready,
    input  logic                 rsp_valid,
    input  logic [ID_W-1:0]      rsp_id,
    output logic [ARB_CNT_W-1:0] outstanding,
    output logic                 err_underflow
);

    arb_state_t           r_state, w_state_next;
    logic                 r_valid, w_valid_next;
    logic [ID_W-1:0]      r_id, w_id_next;
    logic [ID_W-1:0]      r_last, w_last_next;
    logic [NUM_REQ-1:0]   r_gnt, w_gnt_next;
    logic [NUM_REQ-1:0]   r_rsp_vld, w_rsp_hit;
    logic [NUM_REQ-1:0]   w_req_masked;
    logic [ARB_CNT_W-1:0] r_outstanding;
    logic                 r_err;
    logic                 w_any;
    logic [ID_W-1:0]      w_winner;
    logic                 w_accept, w_rsp_ok, w_credit_ok;

    // A requester whose grant is on the wire may still show its old request.
    assign w_req_masked = mem_rd_req & ~r_gnt;

    mplist_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .i_req    (w_req_masked),
        .i_last   (r_last),
        .o_any    (w_any),
        .o_winner (w_winner)
    );

    assign w_accept    = r_valid && mem_rd_ready;
    assign w_credit_ok = r_outstanding < ARB_CNT_W'(MAX_OUTSTANDING);
    assign w_rsp_ok    = rsp_valid && (r_outstanding != '0);

    always_comb begin
        w_state_next = r_state;
        w_valid_next = r_valid;
        w_id_next    = r_id;
        w_last_next  = r_last;
        case (r_state)
            IDLE: begin
                if (w_any && w_credit_ok) begin
                    w_state_next = ISSUE;
                    w_valid_next = 1'b1;
                    w_id_next    = w_winner;
                    w_last_next  = w_winner;
                end
            end
            ISSUE: begin
                if (mem_rd_ready) begin
                    w_state_next = GRANT;
                    w_valid_next = 1'b0;
                end
            end
            GRANT:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Out-of-range response ids match no lane and are silently dropped.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign w_gnt_next[gi] = w_accept && (r_id == ID_W'(gi));
            assign w_rsp_hit[gi]  = w_rsp_ok && (rsp_id == ID_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_valid       <= 1'b0;
            r_id          <= '0;
            r_last        <= ID_W'(NUM_REQ - 1);
            r_gnt         <= '0;
            r_rsp_vld     <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_valid   <= w_valid_next;
            r_id      <= w_id_next;
            r_last    <= w_last_next;
            r_gnt     <= w_gnt_next;
            r_rsp_vld <= w_rsp_hit;
            if (rsp_valid && (r_outstanding == '0)) begin
                r_err <= 1'b1;
            end
            if (w_accept && !w_rsp_ok) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (!w_accept && w_rsp_ok) begin
                r_outstanding <= r_outstanding - 1'b1;
            end
        end
    end

    assign mem_rd_gnt    = r_gnt;
    assign mem_rsp_vld   = r_rsp_vld;
    assign mem_rd_valid  = r_valid;
    assign mem_rd_id     = r_id;
    assign outstanding   = r_outstanding;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_mplist_mem_rd_arb.sv
// Self-checking bench for mplist_mem_rd_arb: grant and response pulses are checked
// against expected {index, cycle} entries queued when the stimulus is driven.
module tb_mplist_mem_rd_arb;

    localparam int NUM_REQ = 4;
    localparam int MAX_OUT = 2;
    localparam int ID_W    = 2;

    typedef struct {
        int id;
        int cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_REQ-1:0] req = '0;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rsp_vld;
    logic               valid;
    logic [ID_W-1:0]    id;
    logic               ready = 1'b0;
    logic               rsp_valid = 1'b0;
    logic [ID_W-1:0]    rsp_id = '0;
    logic [3:0]         outstanding;
    logic               err;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t gnt_q[$];
    exp_t rsp_q[$];

    mplist_mem_rd_arb #(
        .NUM_REQ         (NUM_REQ),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_rd_req    (req),
        .mem_rd_gnt    (gnt),
        .mem_rsp_vld   (rsp_vld),
        .mem_rd_valid  (valid),
        .mem_rd_id     (id),
        .mem_rd_ready  (ready),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .outstanding   (outstanding),
        .err_underflow (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic exp_gnt(input int gid, input int at);
        gnt_q.push_back('{gid, at});
    endtask

    task automatic send_rsp(input int rid, input bit expect_pulse);
        rsp_valid = 1'b1;
        rsp_id    = ID_W'(rid);
        if (expect_pulse) rsp_q.push_back('{rid, cyc + 1});
        tick();
        rsp_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_rspvld"}, 32'(rsp_vld), 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_id"}, 32'(id), 32'd0);
        chk({tag, "_out"}, 32'(outstanding), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Monitor: every grant or response pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (gnt != '0) begin
            $display("txn gnt vec=%b cyc=%0d", gnt, cyc);
            if (gnt_q.size() == 0) begin
                chk("gnt_unexpected", 32'(gnt), 32'd0);
            end else begin
                e = gnt_q.pop_front();
                chk("gnt_vec", 32'(gnt), 32'(1) << e.id);
                chk("gnt_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
        if (rsp_vld != '0) begin
            $display("txn rsp vec=%b cyc=%0d", rsp_vld, cyc);
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_vld), 32'd0);
            end else begin
                e = rsp_q.pop_front();
                chk("rsp_vec", 32'(rsp_vld), 32'(1) << e.id);
                chk("rsp_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        int c;
        repeat (3) tick();
        check_reset("rst");
        reset = 1'b0;

        // Fairness: all requesters held, one response per grant keeps credits free.
        c = cyc;
        req = 4'hF;
        ready = 1'b1;
        for (int k = 0; k < 5; k++) exp_gnt(k % 4, c + 2 + 3 * k);
        for (int t = 1; t <= 15; t++) begin
            tick();
            rsp_valid = 1'b0;
            if (t % 3 == 2) begin
                rsp_valid = 1'b1;
                rsp_id    = ID_W'(((t - 2) / 3) % 4);
                rsp_q.push_back('{((t - 2) / 3) % 4, cyc + 1});
            end
            if (t == 14) req = '0;
        end
        tick();
        rsp_valid = 1'b0;
        chk("fair_out", 32'(outstanding), 32'd0);

        // Single requester 2.
        c = cyc;
        req = 4'b0100;
        exp_gnt(2, c + 2);
        tick();
        chk("single_valid", 32'(valid), 32'd1);
        chk("single_id", 32'(id), 32'd2);
        chk("single_out0", 32'(outstanding), 32'd0);
        tick();
        req = '0;
        chk("single_out", 32'(outstanding), 32'd1);
        tick();
        chk("single_vlow", 32'(valid), 32'd0);
        send_rsp(2, 1'b1);
        chk("single_drain", 32'(outstanding), 32'd0);

        // Backpressure: ready low for 5 accept opportunities.
        c = cyc;
        req = 4'b0010;
        ready = 1'b0;
        exp_gnt(1, c + 7);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("bp_valid", 32'(valid), 32'd1);
            chk("bp_id", 32'(id), 32'd1);
        end
        ready = 1'b1;
        tick();
        req = '0;
        chk("bp_out", 32'(outstanding), 32'd1);
        tick();
        chk("bp_vlow", 32'(valid), 32'd0);

        // Routing to requester 3.
        send_rsp(3, 1'b1);
        chk("route_out", 32'(outstanding), 32'd0);

        // Credit limit of 2: third request waits for a response.
        c = cyc;
        req = 4'b0001;
        exp_gnt(0, c + 2);
        tick();
        tick();
        req = 4'b0010;
        exp_gnt(1, c + 5);
        repeat (3) tick();
        req = 4'b0100;
        chk("credit_full", 32'(outstanding), 32'd2);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("credit_stall_vld", 32'(valid), 32'd0);
        end
        chk("credit_stall_out", 32'(outstanding), 32'd2);
        rsp_valid = 1'b1;
        rsp_id    = 2'd0;
        rsp_q.push_back('{0, cyc + 1});
        tick();
        rsp_valid = 1'b0;
        chk("credit_after_rsp", 32'(outstanding), 32'd1);
        chk("credit_vld_wait", 32'(valid), 32'd0);
        tick();
        chk("credit_resume_vld", 32'(valid), 32'd1);
        chk("credit_resume_id", 32'(id), 32'd2);
        rsp_valid = 1'b1;
        rsp_id    = 2'd1;
        rsp_q.push_back('{1, cyc + 1});
        exp_gnt(2, cyc + 1);
        tick();
        rsp_valid = 1'b0;
        req = '0;
        chk("credit_simul_out", 32'(outstanding), 32'd1);
        tick();
        send_rsp(2, 1'b1);
        chk("credit_drain", 32'(outstanding), 32'd0);

        // Underflow: response with nothing in flight.
        send_rsp(1, 1'b0);
        chk("uf_err", 32'(err), 32'd1);
        chk("uf_out", 32'(outstanding), 32'd0);
        tick();
        tick();
        chk("uf_sticky", 32'(err), 32'd1);

        // Reset while a command is pending in ISSUE.
        req = 4'b0100;
        ready = 1'b0;
        tick();
        chk("rst_issue_vld", 32'(valid), 32'd1);
        reset = 1'b1;
        tick();
        check_reset("rst_mid");
        reset = 1'b0;
        req = '0;
        ready = 1'b1;
        repeat (4) tick();
        chk("rst_no_vld", 32'(valid), 32'd0);

        // Pointer restored: requester 0 beats 3, then 3 follows.
        req = 4'b1001;
        exp_gnt(0, cyc + 2);
        tick();
        tick();
        req = 4'b1000;
        exp_gnt(3, cyc + 3);
        repeat (3) tick();
        req = '0;
        tick();
        chk("ptr_out", 32'(outstanding), 32'd2);
        send_rsp(0, 1'b1);
        send_rsp(3, 1'b1);
        chk("ptr_drain", 32'(outstanding), 32'd0);

        repeat (3) tick();
        chk("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
